power_sequencer_n: RTL



---
 rtl/power_sequencer_n_if.sv | 24 ++
 rtl/power_sequencer_n.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/power_sequencer_n_if.sv
// Request, power-good and status bundle for the N-rail power sequencer.
// The master drives the requests and pgood; the slave is the sequencer.
interface power_sequencer_n_if #(
  parameter int NUM_RAILS = 8
);
  logic                 power_up;
  logic                 power_down;
  logic [NUM_RAILS-1:0] pgood;
  logic [NUM_RAILS-1:0] rail_en;
  logic                 sequence_complete;
  logic                 busy;
  logic                 fault;
  logic [7:0]           fault_rail;

  modport master (
    output power_up, power_down, pgood,
    input  rail_en, sequence_complete, busy, fault, fault_rail
  );

  modport slave (
    input  power_up, power_down, pgood,
    output rail_en, sequence_complete, busy, fault, fault_rail
  );
endinterface

// File: rtl/power_sequencer_n.sv
// N-rail power sequencer: ordered power-up with pgood confirmation, reverse power-down.
// Define PGOOD_MONITOR_EN to also fault on any power-good loss while ON.
module power_sequencer_n #(
  parameter int NUM_RAILS = 8,
  parameter int CNT_W = 32,
  parameter int STEP_DELAY = 1000,
  parameter int PG_TIMEOUT = 10000,
  parameter logic [NUM_RAILS-1:0] ACTIVE_LOW_MASK = '0
) (
  input logic clk,
  input logic reset,
  power_sequencer_n_if.slave bus
);

  localparam logic [2:0] S_OFF       = 3'd0;
  localparam logic [2:0] S_UP_STEP   = 3'd1;
  localparam logic [2:0] S_UP_PG     = 3'd2;
  localparam logic [2:0] S_ON        = 3'd3;
  localparam logic [2:0] S_DOWN_STEP = 3'd4;
  localparam logic [2:0] S_OFF_DONE  = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  localparam logic [7:0] LAST = 8'(NUM_RAILS - 1);
  localparam logic [CNT_W-1:0] STEP_LD = CNT_W'(STEP_DELAY);
  localparam logic [CNT_W-1:0] PG_LD = CNT_W'(PG_TIMEOUT);

  logic [2:0]           state;
  logic [7:0]           idx;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_RAILS-1:0] en;
  logic [NUM_RAILS-1:0] pg_m;
  logic [NUM_RAILS-1:0] pg_s;
  logic                 fault_q;
  logic [7:0]           fault_rail_q;

  logic [NUM_RAILS-1:0] sel;
  logic                 pg_hit;
  logic [7:0]           top_idx;
  logic                 cnt_zero;

  always_comb begin
    sel = '0;
    top_idx = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      sel[i] = (idx == 8'(i));
      if (en[i]) top_idx = 8'(i);
    end
    pg_hit = |(pg_s & sel);
    cnt_zero = (cnt == '0);
  end

`ifdef PGOOD_MONITOR_EN
  logic [NUM_RAILS-1:0] bad;
  logic [7:0]           low_bad;

  always_comb begin
    bad = en & ~pg_s;
    low_bad = '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--)
      if (bad[i]) low_bad = 8'(i);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_OFF;
      idx <= '0;
      cnt <= '0;
      en <= '0;
      pg_m <= '0;
      pg_s <= '0;
      fault_q <= 1'b0;
      fault_rail_q <= '0;
    end else begin
      pg_m <= bus.pgood;
      pg_s <= pg_m;
      unique case (state)
        S_OFF: begin
          en <= '0;
          if (!bus.power_down && bus.power_up) begin
            state <= S_UP_STEP;
            idx <= '0;
            cnt <= STEP_LD;
          end
        end
        S_UP_STEP, S_UP_PG: begin
          // Abort unwinds only the rails already switched on.
          if (bus.power_down) begin
            cnt <= STEP_LD;
            if (en == '0) begin
              state <= S_OFF_DONE;
            end else begin
              state <= S_DOWN_STEP;
              idx <= top_idx;
            end
          end else if (state == S_UP_STEP) begin
            if (!cnt_zero) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              en <= en | sel;
              cnt <= PG_LD;
              state <= S_UP_PG;
            end
          end else if (pg_hit) begin
            if (idx == LAST) begin
              state <= S_ON;
            end else begin
              idx <= idx + 8'd1;
              cnt <= STEP_LD;
              state <= S_UP_STEP;
            end
          end else if (cnt_zero) begin
            state <= S_FAULT;
            en <= '0;
            fault_q <= 1'b1;
            fault_rail_q <= idx;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_ON: begin
`ifdef PGOOD_MONITOR_EN
          if (|bad) begin
            state <= S_FAULT;
            en <= '0;
            fault_q <= 1'b1;
            fault_rail_q <= low_bad;
          end else
`endif
          if (bus.power_down) begin
            state <= S_DOWN_STEP;
            idx <= LAST;
            cnt <= STEP_LD;
          end
        end
        S_DOWN_STEP: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            en <= en & ~sel;
            if (idx == '0) begin
              state <= S_OFF_DONE;
            end else begin
              idx <= idx - 8'd1;
              cnt <= STEP_LD;
            end
          end
        end
        S_OFF_DONE: begin
          if (!bus.power_down) state <= S_OFF;
        end
        S_FAULT: begin
          en <= '0;
          if (bus.power_down) begin
            fault_q <= 1'b0;
            state <= S_OFF_DONE;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

  assign bus.rail_en = en ^ ACTIVE_LOW_MASK;
  assign bus.sequence_complete = (state == S_ON) || (state == S_OFF_DONE);
  assign bus.busy = (state == S_UP_STEP) || (state == S_UP_PG) ||
                    (state == S_DOWN_STEP);
  assign bus.fault = fault_q;
  assign bus.fault_rail = fault_rail_q;

endmodule
